// File: rtl/vec_pkg.sv
// Shared definitions for the vector ALU sequencer: operator encoding,
// default datapath widths and the sequencer FSM state type.
package vec_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  localparam int VEC_LANE_W    = 32;
  localparam int VEC_NUM_LANES = 16;
  localparam int VEC_DATA_W    = VEC_LANE_W * VEC_NUM_LANES;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    EXEC,
    WB_LO,
    WB_HI
  } state_e;

endpackage

// File: rtl/vec_op_counter.sv
// Free-running 32-bit count of retired vector instructions; wraps at 2^32
// and is cleared only by reset.
module vec_op_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/vec_alu_seq.sv
// Single-issue sequencer: read two vector registers, drive the external ALU,
// write the double-width result back as two halves. Optional op_count port
// under VEC_ALU_SEQ_PERF_EN.
module vec_alu_seq
  import vec_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = 2,
  parameter int DATA_W   = VEC_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                instr_op,
  input  logic [REG_AW-1:0]   instr_rs1,
  input  logic [REG_AW-1:0]   instr_rs2,
  input  logic [REG_AW-1:0]   instr_rd,
  output logic [REG_AW-1:0]   rf_raddr1,
  output logic [REG_AW-1:0]   rf_raddr2,
  input  logic [DATA_W-1:0]   rf_rdata1,
  input  logic [DATA_W-1:0]   rf_rdata2,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic                alu_op,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                busy,
  output logic                done
`ifdef VEC_ALU_SEQ_PERF_EN
  ,
  output logic [31:0]         op_count
`endif
);

  localparam logic [REG_AW-1:0] LAST_REG = REG_AW'(NUM_REGS - 1);

  state_e              state_q,  state_d;
  logic                op_q,     op_d;
  logic [REG_AW-1:0]   raddr1_q, raddr1_d;
  logic [REG_AW-1:0]   raddr2_q, raddr2_d;
  logic [REG_AW-1:0]   rd_q,     rd_d;
  logic [DATA_W-1:0]   opa_q,    opa_d;
  logic [DATA_W-1:0]   opb_q,    opb_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                rf_we_q,  rf_we_d;
  logic [REG_AW-1:0]   waddr_q,  waddr_d;
  logic                done_q,   done_d;

  // NOTE: every variable gets its default before the case statement, so no
  // path through this block can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    raddr1_d = raddr1_q;
    raddr2_d = raddr2_q;
    rd_d     = rd_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    waddr_d  = waddr_q;
    rf_we_d  = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d     = instr_op;
          raddr1_d = instr_rs1;
          raddr2_d = instr_rs2;
          rd_d     = instr_rd;
          state_d  = RD;
        end
      end
      RD: begin
        opa_d   = rf_rdata1;
        opb_d   = rf_rdata2;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_result;
        rf_we_d  = 1'b1;
        waddr_d  = rd_q;
        state_d  = WB_LO;
      end
      WB_LO: begin
        // High half goes to the next register, wrapping past the last one.
        rf_we_d = 1'b1;
        waddr_d = (rd_q == LAST_REG) ? '0 : rd_q + REG_AW'(1);
        done_d  = 1'b1;
        state_d = WB_HI;
      end
      WB_HI:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so that every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      raddr1_q <= '0;
      raddr2_q <= '0;
      rd_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      rf_we_q  <= 1'b0;
      waddr_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      raddr1_q <= raddr1_d;
      raddr2_q <= raddr2_d;
      rd_q     <= rd_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      rf_we_q  <= rf_we_d;
      waddr_q  <= waddr_d;
      done_q   <= done_d;
    end
  end

  // Write data selects a half of the captured result; it depends only on flops.
  always_comb begin
    rf_wdata = '0;
    case (state_q)
      WB_LO:   rf_wdata = result_q[DATA_W-1:0];
      WB_HI:   rf_wdata = result_q[2*DATA_W-1:DATA_W];
      default: rf_wdata = '0;
    endcase
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rf_raddr1   = raddr1_q;
  assign rf_raddr2   = raddr2_q;
  assign alu_a       = opa_q;
  assign alu_b       = opb_q;
  assign alu_op      = op_q;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = waddr_q;
  assign done        = done_q;

`ifdef VEC_ALU_SEQ_PERF_EN
  vec_op_counter u_op_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state_q == WB_HI),
    .count (op_count)
  );
`endif

endmodule

// File: tb/tb_vec_alu_seq.sv
// Self-checking bench for vec_alu_seq: bench-side register file and ALU,
// with a per-instruction reference model of the architectural registers.
module tb_vec_alu_seq;
  import vec_pkg::*;

  localparam int NR = 4;
  localparam int AW = 2;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            instr_valid, instr_ready, instr_op;
  logic [AW-1:0]   instr_rs1, instr_rs2, instr_rd;
  logic [AW-1:0]   rf_raddr1, rf_raddr2, rf_waddr;
  logic [DW-1:0]   rf_rdata1, rf_rdata2, alu_a, alu_b, rf_wdata;
  logic            alu_op, rf_we, busy, done;
  logic [2*DW-1:0] alu_result;
`ifdef VEC_ALU_SEQ_PERF_EN
  logic [31:0]     op_count;
`endif

  always #5 clk = ~clk;

  vec_alu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .done(done)
`ifdef VEC_ALU_SEQ_PERF_EN
    , .op_count(op_count)
`endif
  );

  // 16 lanes of 32 bits in, 16 lanes of 64 bits out.
  function automatic logic [2*DW-1:0] alu_f(input logic op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [2*DW-1:0] r;
    logic [63:0] x, y;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      x = {32'd0, a[32*i +: 32]};
      y = {32'd0, b[32*i +: 32]};
      r[64*i +: 64] = op ? (x + y) : (x * y);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Bench register file: address registered by the DUT, data visible in RD.
  logic [DW-1:0] rf_mem [NR];
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;

  always @(posedge clk) begin
    if (rf_we)        rf_mem[rf_waddr] <= rf_wdata;
    else if (load_en) rf_mem[load_addr] <= load_data;
  end

  assign rf_rdata1  = rf_mem[rf_raddr1];
  assign rf_rdata2  = rf_mem[rf_raddr2];
  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t wr_log[$];
  int  done_log[$];

  // A write seen at a negedge commits on the following rising edge.
  always @(negedge clk) begin
    if (rf_we) wr_log.push_back('{cyc + 1, rf_waddr, rf_wdata});
    if (done)  done_log.push_back(cyc);
  end

  logic [DW-1:0] model [NR];
  int checks = 0;
  int errors = 0;
  int n_retired = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
    model[a]  = d;
  endtask

  task automatic accept(input logic op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, output int t0);
    instr_op    = op;
    instr_rs1   = rs1;
    instr_rs2   = rs2;
    instr_rd    = rd;
    instr_valid = 1'b1;
    t0 = -1;
    for (int k = 0; k < 20; k++) begin
      if (instr_ready) begin
        t0 = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    check("accept_seen", 512'(t0 >= 0), 512'(1));
    @(negedge clk);
  endtask

  task automatic retire(input int t0, input logic op, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic [AW-1:0] rd);
    logic [2*DW-1:0] exp;
    logic [AW-1:0]   rd_hi;
    wr_t lo, hi;
    exp   = alu_f(op, model[rs1], model[rs2]);
    rd_hi = AW'((int'(rd) + 1) % NR);
    for (int k = 0; k < 30 && wr_log.size() < 2; k++) @(negedge clk);
    check("wb_count", 512'(wr_log.size() >= 2), 512'(1));
    if (wr_log.size() >= 2) begin
      lo = wr_log.pop_front();
      hi = wr_log.pop_front();
      check("wb_lo_cycle", 512'(lo.c), 512'(t0 + 3));
      check("wb_lo_addr",  512'(lo.a), 512'(rd));
      check("wb_lo_data",  lo.d, exp[DW-1:0]);
      check("wb_hi_cycle", 512'(hi.c), 512'(t0 + 4));
      check("wb_hi_addr",  512'(hi.a), 512'(rd_hi));
      check("wb_hi_data",  hi.d, exp[2*DW-1:DW]);
    end
    check("done_count", 512'(done_log.size() >= 1), 512'(1));
    if (done_log.size() >= 1) check("done_cycle", 512'(done_log.pop_front()), 512'(t0 + 3));
    model[rd]    = exp[DW-1:0];
    model[rd_hi] = exp[2*DW-1:DW];
    n_retired++;
  endtask

  task automatic check_rf();
    for (int k = 0; k < 30 && busy; k++) @(negedge clk);
    check("idle_reached", 512'(busy), 512'(0));
    for (int i = 0; i < NR; i++) check($sformatf("rf%0d", i), rf_mem[i], model[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, nready;
    logic op;
    logic [AW-1:0] s1, s2, d;

    instr_valid = 1'b0;
    instr_op    = 1'b0;
    instr_rs1   = '0;
    instr_rs2   = '0;
    instr_rd    = '0;

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",  512'(instr_ready), 512'(1));
    check("rst_busy",   512'(busy),        512'(0));
    check("rst_we",     512'(rf_we),       512'(0));
    check("rst_done",   512'(done),        512'(0));
    check("rst_raddr1", 512'(rf_raddr1),   512'(0));
    check("rst_raddr2", 512'(rf_raddr2),   512'(0));
    check("rst_waddr",  512'(rf_waddr),    512'(0));
    check("rst_wdata",  rf_wdata,          '0);
    check("rst_alu_a",  alu_a,             '0);
    check("rst_alu_b",  alu_b,             '0);
    check("rst_alu_op", 512'(alu_op),      512'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_ready",  512'(instr_ready),     512'(1));
    check("idle_writes", 512'(wr_log.size()),   512'(0));
    check("idle_done",   512'(done_log.size()), 512'(0));

    // Add: 0xFFFFFFFF + 1 in every lane
    load(2'd0, {16{32'hFFFF_FFFF}});
    load(2'd1, {16{32'h0000_0001}});
    load(2'd2, '0);
    load(2'd3, '0);
    accept(OP_ADD, 2'd0, 2'd1, 2'd2, t0);
    instr_valid = 1'b0;
    check("add_busy",  512'(busy),        512'(1));
    check("add_ready", 512'(instr_ready), 512'(0));
    retire(t0, OP_ADD, 2'd0, 2'd1, 2'd2);
    check_rf();
    check("add_r2_const", rf_mem[2], {8{64'h0000_0001_0000_0000}});
    check("add_r3_const", rf_mem[3], {8{64'h0000_0001_0000_0000}});

    // Multiply with destination wrap: r3 then r0
    load(2'd1, {16{32'hFFFF_FFFF}});
    load(2'd2, {16{32'hFFFF_FFFF}});
    accept(OP_MUL, 2'd1, 2'd2, 2'd3, t0);
    instr_valid = 1'b0;
    retire(t0, OP_MUL, 2'd1, 2'd2, 2'd3);
    check_rf();
    check("mul_r3_const", rf_mem[3], {8{64'hFFFF_FFFE_0000_0001}});
    check("mul_r0_const", rf_mem[0], {8{64'hFFFF_FFFE_0000_0001}});

    // Back-to-back issue with instr_valid held high
    for (int i = 0; i < NR; i++) load(AW'(i), rand512());
    op = 1'($urandom_range(0, 1));
    s1 = AW'($urandom_range(0, 3));
    s2 = AW'($urandom_range(0, 3));
    d  = AW'($urandom_range(0, 3));
    accept(op, s1, s2, d, t0);
    instr_op  = ~op;
    instr_rs1 = d;
    instr_rs2 = s1;
    instr_rd  = s2;
    nready = 0;
    for (int k = 0; k < 10 && !instr_ready; k++) begin
      nready++;
      @(negedge clk);
    end
    accept(~op, d, s1, s2, t1);
    instr_valid = 1'b0;
    check("b2b_spacing",   512'(t1 - t0), 512'(5));
    check("b2b_not_ready", 512'(nready),  512'(4));
    retire(t0, op, s1, s2, d);
    retire(t1, ~op, d, s1, s2);
    check_rf();

    // Overlapping destination: sources are r0/r1, results land in r0/r1
    for (int i = 0; i < NR; i++) load(AW'(i), rand512());
    op = 1'($urandom_range(0, 1));
    accept(op, 2'd0, 2'd1, 2'd0, t0);
    instr_valid = 1'b0;
    retire(t0, op, 2'd0, 2'd1, 2'd0);
    check_rf();

    // Random instructions against the evolving register model
    for (int n = 0; n < 6; n++) begin
      op = 1'($urandom_range(0, 1));
      s1 = AW'($urandom_range(0, 3));
      s2 = AW'($urandom_range(0, 3));
      d  = AW'($urandom_range(0, 3));
      accept(op, s1, s2, d, t0);
      instr_valid = 1'b0;
      retire(t0, op, s1, s2, d);
      check_rf();
    end

`ifdef VEC_ALU_SEQ_PERF_EN
    check("op_count", 512'(op_count), 512'(n_retired));
`endif

    // Reset asserted during EXEC: no write-back may follow
    wr_log.delete();
    done_log.delete();
    accept(OP_ADD, 2'd1, 2'd2, 2'd3, t0);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we",    512'(rf_we),       512'(0));
    check("mid_rst_ready", 512'(instr_ready), 512'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_writes", 512'(wr_log.size()),   512'(0));
    check("mid_rst_done",   512'(done_log.size()), 512'(0));
    check("mid_rst_busy",   512'(busy),            512'(0));
    check("mid_rst_alu_a",  alu_a,                 '0);
`ifdef VEC_ALU_SEQ_PERF_EN
    check("mid_rst_count", 512'(op_count), 512'(0));
`endif
    check_rf();

    // Sequencer still works after the interrupted instruction
    accept(OP_MUL, 2'd2, 2'd3, 2'd1, t0);
    instr_valid = 1'b0;
    retire(t0, OP_MUL, 2'd2, 2'd3, 2'd1);
    check_rf();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
